// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider and its
// companion multiplier bench: FSM state encoding and magnitude helpers.
package div_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      ITER,
      FIXUP,
      DONE
   } state_t;

   localparam int unsigned DIV_W = 4;
   localparam int unsigned CNT_W = $clog2(DIV_W);

   // Helpers work on 64 bits so any operand width up to 32 can sign-extend into them.
   function automatic logic [63:0] neg64(input logic [63:0] v);
      return ~v + 64'd1;
   endfunction

   function automatic logic [63:0] abs64(input logic signed [63:0] v);
      return v[63] ? neg64(v) : v;
   endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step on unsigned magnitudes: shift {rem,quo} left
// by one and subtract the divisor when it fits.
module div_restore_step #(
   parameter int W = 4
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] quo,
   input  logic [W:0]   dmag,
   output logic [W-1:0] rem_next,
   output logic [W-1:0] quo_next
);

   logic [W:0] shifted;

   // rem < dmag <= 2^(W-1) on entry, so the shifted value and the difference fit W bits.
   always_comb begin
      shifted = {rem, quo[W-1]};
      if (shifted >= dmag) begin
         rem_next = shifted[W-1:0] - dmag[W-1:0];
         quo_next = {quo[W-2:0], 1'b1};
      end else begin
         rem_next = shifted[W-1:0];
         quo_next = {quo[W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/signed_seq_divider.sv
// Sequential two's-complement divider: 2W-bit dividend by W-bit divisor,
// truncating quotient and dividend-signed remainder, one restoring step per cycle.
module signed_seq_divider
   import div_pkg::*;
#(
   parameter int W = DIV_W
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2*W-1:0]  P,
   input  logic [W-1:0]    M,
   output logic [W-1:0]    Q,
   output logic [W-1:0]    R,
   output logic            busy,
   output logic            done,
   output logic            div_by_zero,
   output logic            overflow
);

   localparam int PW = 2 * W;
   localparam int CW = (W > 2) ? $clog2(W) : 1;
   localparam logic [W-1:0] ONE_W     = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] Q_POS_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] Q_NEG_MAX = {1'b1, {(W-1){1'b0}}};

   state_t               state, state_nxt;
   logic signed [PW-1:0] p_lat, p_nxt;
   logic signed [W-1:0]  m_lat, m_nxt;
   logic [W-1:0]         rem, rem_nxt;
   logic [W-1:0]         quo, quo_nxt;
   logic [W:0]           dmag, dmag_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic                 sign_q, sign_q_nxt;
   logic                 sign_r, sign_r_nxt;
   logic [W-1:0]         q_nxt, r_nxt;
   logic                 dbz_nxt, ovf_nxt, done_nxt;

   logic [PW:0]          p_mag;
   logic [W:0]           m_mag;
   logic [W-1:0]         rem_step, quo_step;
   logic [W-1:0]         q_fix, r_fix;
   logic                 q_range_err;

   // One extra magnitude bit keeps -2^(PW-1) and -2^(W-1) exact.
   assign p_mag = (PW+1)'(abs64(64'(p_lat)));
   assign m_mag = (W+1)'(abs64(64'(m_lat)));
   assign busy  = (state != IDLE);

   div_restore_step #(.W(W)) u_step (
      .rem      (rem),
      .quo      (quo),
      .dmag     (dmag),
      .rem_next (rem_step),
      .quo_next (quo_step)
   );

   assign q_fix       = sign_q ? (~quo + ONE_W) : quo;
   assign r_fix       = sign_r ? (~rem + ONE_W) : rem;
   assign q_range_err = sign_q ? (quo > Q_NEG_MAX) : (quo > Q_POS_MAX);

   always_comb begin
      state_nxt  = state;
      p_nxt      = p_lat;
      m_nxt      = m_lat;
      rem_nxt    = rem;
      quo_nxt    = quo;
      dmag_nxt   = dmag;
      cnt_nxt    = cnt;
      sign_q_nxt = sign_q;
      sign_r_nxt = sign_r;
      q_nxt      = Q;
      r_nxt      = R;
      dbz_nxt    = div_by_zero;
      ovf_nxt    = overflow;
      done_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               p_nxt     = P;
               m_nxt     = M;
               dbz_nxt   = 1'b0;
               ovf_nxt   = 1'b0;
               state_nxt = PREP;
            end
         end
         PREP: begin
            sign_q_nxt = p_lat[PW-1] ^ m_lat[W-1];
            sign_r_nxt = p_lat[PW-1];
            if (m_mag == '0) begin
               dbz_nxt   = 1'b1;
               q_nxt     = '0;
               r_nxt     = '0;
               done_nxt  = 1'b1;
               state_nxt = DONE;
            end else if (p_mag[PW:W] >= m_mag) begin
               // Quotient magnitude would need more than W bits.
               ovf_nxt   = 1'b1;
               q_nxt     = '0;
               r_nxt     = '0;
               done_nxt  = 1'b1;
               state_nxt = DONE;
            end else begin
               rem_nxt   = p_mag[PW-1:W];
               quo_nxt   = p_mag[W-1:0];
               dmag_nxt  = m_mag;
               cnt_nxt   = CW'(W - 1);
               state_nxt = ITER;
            end
         end
         ITER: begin
            rem_nxt = rem_step;
            quo_nxt = quo_step;
            if (cnt == '0) begin
               state_nxt = FIXUP;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         FIXUP: begin
            if (q_range_err) begin
               ovf_nxt = 1'b1;
               q_nxt   = '0;
               r_nxt   = '0;
            end else begin
               q_nxt = q_fix;
               r_nxt = r_fix;
            end
            done_nxt  = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         p_lat       <= '0;
         m_lat       <= '0;
         rem         <= '0;
         quo         <= '0;
         dmag        <= '0;
         cnt         <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         Q           <= '0;
         R           <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nxt;
         p_lat       <= p_nxt;
         m_lat       <= m_nxt;
         rem         <= rem_nxt;
         quo         <= quo_nxt;
         dmag        <= dmag_nxt;
         cnt         <= cnt_nxt;
         sign_q      <= sign_q_nxt;
         sign_r      <= sign_r_nxt;
         Q           <= q_nxt;
         R           <= r_nxt;
         div_by_zero <= dbz_nxt;
         overflow    <= ovf_nxt;
         done        <= done_nxt;
      end
   end

endmodule

// File: tb/tb_signed_seq_divider.sv
// Bench for signed_seq_divider (W=4): latency-level reference model checked
// every cycle, directed corner cases, random division and multiply round trips.
module tb_signed_seq_divider;

   localparam int W = 4;

   typedef struct {
      int q;
      int r;
      bit dbz;
      bit ovf;
   } res_t;

   logic           clk   = 1'b0;
   logic           reset = 1'b1;
   logic           start = 1'b0;
   logic [2*W-1:0] P     = '0;
   logic [W-1:0]   M     = '0;
   logic [W-1:0]   Q, R;
   logic           busy, done, div_by_zero, overflow;

   int checks = 0;
   int errors = 0;

   int   busy_left = 0;
   int   exp_q = 0, exp_r = 0;
   bit   exp_dbz = 0, exp_ovf = 0;
   res_t pend;

   signed_seq_divider #(.W(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .P           (P),
      .M           (M),
      .Q           (Q),
      .R           (R),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Truncating signed division; results outside the W-bit signed range are overflow.
   function automatic res_t model(input int p, input int m);
      res_t res;
      res.q = 0; res.r = 0; res.dbz = 0; res.ovf = 0;
      if (m == 0) begin
         res.dbz = 1;
      end else begin
         res.q = p / m;
         res.r = p % m;
         if (res.q > (1 << (W-1)) - 1 || res.q < -(1 << (W-1))) begin
            res.ovf = 1; res.q = 0; res.r = 0;
         end
      end
      return res;
   endfunction

   // Errors found before iterating: zero divisor or quotient magnitude needing more than W bits.
   function automatic bit early_err(input int p, input int m);
      if (m == 0) return 1'b1;
      return (iabs(p) / iabs(m)) >= (1 << W);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: busy for the whole operation, done on its last busy cycle.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_left <= 0;
         exp_q     <= 0;
         exp_r     <= 0;
         exp_dbz   <= 0;
         exp_ovf   <= 0;
      end else if (busy_left == 0) begin
         if (start) begin
            pend      <= model(int'($signed(P)), int'($signed(M)));
            busy_left <= early_err(int'($signed(P)), int'($signed(M))) ? 2 : W + 3;
            exp_dbz   <= 0;
            exp_ovf   <= 0;
         end
      end else begin
         busy_left <= busy_left - 1;
         if (busy_left == 2) begin
            exp_q   <= pend.q;
            exp_r   <= pend.r;
            exp_dbz <= pend.dbz;
            exp_ovf <= pend.ovf;
         end
      end
   end

   always @(negedge clk) begin
      chk("busy", int'(busy), int'(busy_left != 0));
      chk("done", int'(done), int'(busy_left == 1));
      chk("Q", int'($signed(Q)), exp_q);
      chk("R", int'($signed(R)), exp_r);
      chk("div_by_zero", int'(div_by_zero), int'(exp_dbz));
      chk("overflow", int'(overflow), int'(exp_ovf));
   end

   // glitch: 1 = re-pulse start mid-ITER, 2 = pulse start during the DONE cycle.
   task automatic op(input int p, input int m, input int glitch, output int lat);
      @(negedge clk);
      start = 1'b1;
      P = (2*W)'(p);
      M = W'(m);
      @(negedge clk);
      start = 1'b0;
      P = (2*W)'($urandom);
      M = W'($urandom);
      lat = 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
         if (glitch == 1 && lat == 2) start = 1'b1;
         if (glitch == 1 && lat == 3) start = 1'b0;
      end
      if (!done) chk("done_timeout", 0, 1);
      if (glitch == 2) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic lit(input string name, input int q, input int r, input int z, input int o);
      chk({name, "_Q"}, int'($signed(Q)), q);
      chk({name, "_R"}, int'($signed(R)), r);
      chk({name, "_dbz"}, int'(div_by_zero), z);
      chk({name, "_ovf"}, int'(overflow), o);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      res_t ref_r;
      int   lat, m, q0, nd;

      #2 reset = 1'b0;
      #1 lit("reset", 0, 0, 0, 0);
      chk("reset_busy", int'(busy), 0);
      #29 reset = 1'b1;

      ref_r = model(20, 3);
      chk("pin_20_3_q", ref_r.q, 6);
      chk("pin_20_3_r", ref_r.r, 2);
      ref_r = model(-20, 3);
      chk("pin_m20_3_r", ref_r.r, -2);
      ref_r = model(-24, 3);
      chk("pin_m24_3_q", ref_r.q, -8);
      ref_r = model(40, 5);
      chk("pin_40_5_ovf", int'(ref_r.ovf), 1);

      op(20, 3, 0, lat);     chk("lat_normal", lat, W + 2); lit("p20_m3", 6, 2, 0, 0);
      op(-20, 3, 0, lat);    lit("pm20_m3", -6, -2, 0, 0);
      op(20, -3, 0, lat);    lit("p20_mm3", -6, 2, 0, 0);
      op(7, 0, 0, lat);      chk("lat_dbz", lat, 1); lit("dbz", 0, 0, 1, 0);
      op(64, 3, 0, lat);     chk("lat_ovf", lat, 1); lit("ovf_64_3", 0, 0, 0, 1);
      op(-24, 3, 0, lat);    lit("qmin", -8, 0, 0, 0);
      op(-128, -1, 0, lat);  lit("ovf_m128", 0, 0, 0, 1);
      op(40, 5, 0, lat);     chk("lat_late_ovf", lat, W + 2); lit("ovf_40_5", 0, 0, 0, 1);
      op(0, -5, 0, lat);     lit("zero_div", 0, 0, 0, 0);
      op(-6, 3, 0, lat);     lit("neg_exact", -2, 0, 0, 0);
      op(20, 3, 1, lat);     lit("restart_iter", 6, 2, 0, 0);
      op(-20, 3, 2, lat);    lit("restart_done", -6, -2, 0, 0);

      // Abort in the middle of ITER.
      @(negedge clk);
      start = 1'b1; P = 8'd20; M = 4'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      #1 lit("abort", 0, 0, 0, 0);
      chk("abort_busy", int'(busy), 0);
      #2 reset = 1'b1;
      nd = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("abort_no_done", nd, 0);

      repeat (150) begin
         op(int'($signed(8'($urandom))), int'($signed(4'($urandom))), 0, lat);
      end

      repeat (100) begin
         m = int'($urandom_range(0, 15)) - 8;
         if (m == 0) m = 1;
         q0 = int'($urandom_range(0, 15)) - 8;
         op(m * q0, m, 0, lat);
         chk("roundtrip_Q", int'($signed(Q)), q0);
         chk("roundtrip_R", int'($signed(R)), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
